// File: rtl/rx_block_lock.sv
// 10GBASE-R receive block-lock FSM: hunts for sync-header alignment by
// slipping the gearbox one bit at a time, then holds lock until too many bad headers.
module rx_block_lock #(
  parameter int VALID_THRESH   = 64,
  parameter int INVALID_THRESH = 16,
  parameter int SLIP_WAIT      = 4
) (
  input  logic       i_rxc,
  input  logic       i_reset,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_header_valid,
  input  logic       i_rx_data_valid,
  output logic       o_slip,
  output logic       o_block_lock
);

  localparam int SH_W = $clog2(VALID_THRESH + 1);
  localparam int INV_W = $clog2(INVALID_THRESH + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0] SH_MAX = SH_W'(VALID_THRESH);
  localparam logic [INV_W-1:0] INV_MAX = INV_W'(INVALID_THRESH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT);

  typedef enum logic {
    ST_TEST_SH,
    ST_SLIP_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SH_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic slip_q, slip_d;
  logic lock_q, lock_d;

  logic qual;
  logic hdr_inv;
  logic [SH_W-1:0] sh_n;
  logic [INV_W-1:0] inv_n;
  logic [WAIT_W-1:0] wait_n;

  assign qual = i_rx_header_valid & i_rx_data_valid;
  // Valid sync headers have differing bits (01 or 10).
  assign hdr_inv = ~(i_rx_header[1] ^ i_rx_header[0]);

  assign sh_n = sh_cnt_q + SH_W'(1);
  assign inv_n = inv_cnt_q + INV_W'(hdr_inv);
  assign wait_n = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d = state_q;
    sh_cnt_d = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d = 1'b0;
    lock_d = lock_q;

    unique case (state_q)
      ST_TEST_SH: begin
        if (qual) begin
          if (!lock_q && inv_n != '0) begin
            slip_d = 1'b1;
            sh_cnt_d = '0;
            inv_cnt_d = '0;
            state_d = ST_SLIP_WAIT;
          end else if (lock_q && inv_n == INV_MAX) begin
            lock_d = 1'b0;
            slip_d = 1'b1;
            sh_cnt_d = '0;
            inv_cnt_d = '0;
            state_d = ST_SLIP_WAIT;
          end else if (sh_n == SH_MAX) begin
            if (inv_n == '0) begin
              lock_d = 1'b1;
            end
            sh_cnt_d = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_n;
            inv_cnt_d = inv_n;
          end
        end
      end
      ST_SLIP_WAIT: begin
        lock_d = 1'b0;
        if (qual) begin
          // Headers here are stale gearbox output; count them, never judge them.
          if (wait_n == WAIT_MAX) begin
            wait_cnt_d = '0;
            sh_cnt_d = '0;
            inv_cnt_d = '0;
            state_d = ST_TEST_SH;
          end else begin
            wait_cnt_d = wait_n;
          end
        end
      end
      default: begin
        state_d = ST_TEST_SH;
      end
    endcase
  end

  always_ff @(posedge i_rxc) begin
    if (i_reset) begin
      state_q <= ST_TEST_SH;
      sh_cnt_q <= '0;
      inv_cnt_q <= '0;
      wait_cnt_q <= '0;
      slip_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_cnt_q <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q <= slip_d;
      lock_q <= lock_d;
    end
  end

  assign o_slip = slip_q;
  assign o_block_lock = lock_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: short vector table plus
// long hand-written sequences for window, slip and reset corners.
module tb_rx_block_lock;

  logic       clk;
  logic       rst;
  logic [1:0] hdr;
  logic       hv;
  logic       dv;
  logic       slip;
  logic       lock;

  int n_run;
  int n_fail;

  rx_block_lock dut (
    .i_rxc            (clk),
    .i_reset          (rst),
    .i_rx_header      (hdr),
    .i_rx_header_valid(hv),
    .i_rx_data_valid  (dv),
    .o_slip           (slip),
    .o_block_lock     (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] hdr;
    logic       hv;
    logic       dv;
    logic       slip;
    logic       lock;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic es, input logic el);
    n_run++;
    if (slip !== es || lock !== el) begin
      n_fail++;
      $display("FAIL %s: slip=%0b lock=%0b, expected slip=%0b lock=%0b",
               name, slip, lock, es, el);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] h,
                     input logic v, input logic d);
    rst = r;
    hdr = h;
    hv = v;
    dv = d;
    @(posedge clk);
    #1;
  endtask

  // One qualified header, then an idle cycle; both checked.
  task automatic send(input string name, input logic [1:0] h,
                      input logic es, input logic el);
    cyc(1'b0, h, 1'b1, 1'b1);
    check(name, es, el);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    check({name, "_idle"}, 1'b0, el);
  endtask

  task automatic set_vec(input int i, input logic r, input logic [1:0] h,
                         input logic v, input logic d,
                         input logic es, input logic el);
    vec[i].rst = r;
    vec[i].hdr = h;
    vec[i].hv = v;
    vec[i].dv = d;
    vec[i].slip = es;
    vec[i].lock = el;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    hdr = 2'b00;
    hv = 1'b0;
    dv = 1'b0;

    set_vec(0, 1, 2'b01, 1, 1, 0, 0);
    set_vec(1, 0, 2'b01, 1, 1, 0, 0);
    set_vec(2, 0, 2'b00, 0, 1, 0, 0);
    set_vec(3, 0, 2'b11, 1, 0, 0, 0);
    set_vec(4, 0, 2'b10, 1, 1, 0, 0);
    set_vec(5, 0, 2'b00, 1, 1, 1, 0);
    set_vec(6, 0, 2'b01, 0, 0, 0, 0);
    set_vec(7, 0, 2'b11, 1, 1, 0, 0);
    set_vec(8, 0, 2'b00, 1, 1, 0, 0);
    set_vec(9, 0, 2'b11, 1, 0, 0, 0);
    set_vec(10, 0, 2'b11, 1, 1, 0, 0);
    set_vec(11, 0, 2'b00, 1, 1, 0, 0);
    set_vec(12, 0, 2'b11, 1, 1, 1, 0);
    set_vec(13, 0, 2'b01, 0, 1, 0, 0);
    set_vec(14, 0, 2'b01, 1, 1, 0, 0);

    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    check("reset", 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      cyc(vec[i].rst, vec[i].hdr, vec[i].hv, vec[i].dv);
      check($sformatf("vec%0d", i), vec[i].slip, vec[i].lock);
    end

    // Acquire with 100 unqualified 2'b11 headers mid-run.
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    check("acq_reset", 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 31) begin
        for (int k = 0; k < 100; k++) begin
          cyc(1'b0, 2'b11, 1'b1, 1'b0);
          check("acq_unqual", 1'b0, 1'b0);
        end
      end
      send($sformatf("acq_h%0d", i), 2'b01, 1'b0, i == 64);
    end

    // Unlocked: 10th header bad, 4 ignored bad headers, then reacquire.
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    check("slip_reset", 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      send($sformatf("pre_h%0d", i), 2'b10, 1'b0, 1'b0);
    send("slip_h10", 2'b00, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++)
      send($sformatf("wait_h%0d", i), 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++)
      send($sformatf("reacq_h%0d", i), 2'b01, 1'b0, i == 64);

    // Locked: 15 bad in a window holds; next window's 16th bad at 40 drops.
    for (int i = 1; i <= 64; i++)
      send($sformatf("w15_h%0d", i), (i <= 15) ? 2'b11 : 2'b10, 1'b0, 1'b1);
    for (int i = 1; i <= 40; i++)
      send($sformatf("w16_h%0d", i), (i >= 25) ? 2'b00 : 2'b01,
           i == 40, i != 40);

    // Flush the wait, relock, then 16th bad on the 64th header.
    for (int i = 1; i <= 4; i++)
      send($sformatf("w2_h%0d", i), 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++)
      send($sformatf("relock_h%0d", i), 2'b01, 1'b0, i == 64);
    for (int i = 1; i <= 64; i++)
      send($sformatf("edge_h%0d", i), (i >= 49) ? 2'b11 : 2'b01,
           i == 64, i != 64);

    // Reset mid-wait: a fresh 64-header window is needed.
    send("rw_h1", 2'b01, 1'b0, 1'b0);
    send("rw_h2", 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b1);
    check("rst_in_wait", 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++)
      send($sformatf("pw_h%0d", i), 2'b01, 1'b0, i == 64);

    // Reset mid-window while locked.
    for (int i = 1; i <= 30; i++)
      send($sformatf("lw_h%0d", i), 2'b10, 1'b0, 1'b1);
    cyc(1'b1, 2'b10, 1'b1, 1'b1);
    check("rst_in_lock", 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++)
      send($sformatf("pl_h%0d", i), 2'b10, 1'b0, i == 64);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Clause 49 block-lock state machine for the 10GBASE-R receive PCS. It monitors the 2-bit sync header of each received 66-bit block on the 32-bit receive path, delivered on the same header/data-valid strobes the decoder consumes. It commands the receive gearbox to slip by one bit until header alignment is found, and asserts block lock once alignment is established. `o_block_lock` gates the descrambler and decoder stages downstream.

## Interface

Parameters:
- `VALID_THRESH`, default 64: headers per test window; the window must be all-valid to acquire lock.
- `INVALID_THRESH`, default 16: invalid headers within one window that cause loss of lock.
- `SLIP_WAIT`, default 4: qualified headers ignored after each slip, to allow the gearbox pipeline to flush.

Ports:
- `i_rxc`, input, 1: receive clock.
- `i_reset`, input, 1: reset, synchronous, active-high.
- `i_rx_header`, input, 2: sync header of the current block.
- `i_rx_header_valid`, input, 1: `i_rx_header` is valid; high on the first 32-bit word of each block.
- `i_rx_data_valid`, input, 1: gearbox output word valid.
- `o_slip`, output, 1: one-cycle request for the gearbox to slip one bit.
- `o_block_lock`, output, 1: block alignment achieved.

## Operation

- A qualified header is a cycle with `i_rx_header_valid && i_rx_data_valid`. Every other cycle is ignored by the block, including cycles where `i_rx_header_valid` is high without `i_rx_data_valid`.
- A header is valid when it is 2'b01 or 2'b10. Headers 2'b00 and 2'b11 are invalid.
- Counters:
  - `sh_cnt` is wide enough to hold `VALID_THRESH`.
  - `inv_cnt` is wide enough to hold `INVALID_THRESH`.
  - `wait_cnt` is wide enough to hold `SLIP_WAIT`.
  - Counters never wrap; they are cleared explicitly.
- States: TEST_SH, SLIP_WAIT.
- TEST_SH, on each qualified header:
  - Compute next counts: `sh_n = sh_cnt+1`, and `inv_n = inv_cnt + (header invalid)`.
  - If `!o_block_lock && inv_n != 0`: assert slip, clear counters, go to SLIP_WAIT.
  - Else if `o_block_lock && inv_n == INVALID_THRESH`: deassert `o_block_lock`, assert slip, clear counters, go to SLIP_WAIT.
  - Else if `sh_n == VALID_THRESH`: the window is complete. If `inv_n == 0`, set `o_block_lock`. If locked with fewer than `INVALID_THRESH` invalid headers, stay locked. Clear both counters.
  - Else store `sh_n` and `inv_n`.
- SLIP_WAIT:
  - `o_block_lock` is 0.
  - Each qualified header increments `wait_cnt` and is not evaluated.
  - When `wait_cnt` reaches `SLIP_WAIT`, clear `wait_cnt` and return to TEST_SH with `sh_cnt` and `inv_cnt` both 0.
  - The header that completes the wait is not evaluated; evaluation starts with the next qualified header.
- Priority on a single header: the slip/unlock condition beats window completion. A 64th header that is also the 16th invalid causes a slip, not a retained lock.

## Timing

- Reset values: `o_slip`=0, `o_block_lock`=0, state TEST_SH, all counters 0.
- Reset takes effect on the next edge from any state, including mid-wait and mid-window; outputs are 0 the following cycle.
- All outputs are registered.
- `o_slip` is high for exactly one `i_rxc` cycle, on the cycle after the edge that sampled the offending qualified header.
- `o_block_lock` changes on the same edge as the decision:
  - It rises one cycle after the `VALID_THRESH`-th qualified header.
  - It falls one cycle after the triggering invalid header, coincident with `o_slip`.
- Minimum spacing between two `o_slip` pulses: `SLIP_WAIT`+1 qualified headers.
- There are no combinational paths from inputs to outputs.

## Test plan

- Reset, then 64 qualified headers of 2'b01 on alternate cycles: `o_block_lock` rises exactly one cycle after the 64th, and `o_slip` stays 0.
- Unlocked, with the 10th header 2'b00:
  - `o_slip` pulses for one cycle.
  - The next 4 headers are ignored, even if invalid.
  - Then 64 valid headers produce lock.
- Locked, with a window containing 15 invalid headers: lock is held and counters clear at window end. The next window with its 16th invalid header at position 40: `o_block_lock` falls and `o_slip` pulses in the same cycle.
- `i_rx_header_valid`=1 with `i_rx_data_valid`=0 carrying 2'b11, repeated 100 times during a valid run: no slip, and the lock timing is unchanged.
- Locked, 63rd and 64th headers: the 64th is the 16th invalid in the window, so the slip wins and `o_block_lock` goes to 0.
- `i_reset` asserted during SLIP_WAIT and during a locked window: outputs are 0 on the next cycle, and after release lock needs a full 64 fresh valid headers.
